// File: rtl/apb_master_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_fsm_if
// Description : Bundles the request/response port and the APB bus of the
//               APB requester.
//               master modport : the requester (apb_master_fsm)
//               slave modport  : the environment, i.e. the request source
//                                plus the APB slave(s) behind the mux
//               Request : req_valid, req_ready, req_write, req_addr, req_wdata
//               Response: rsp_valid, rsp_rdata, rsp_err
//               APB     : Paddr, Pwdata, Pwrite, Penable, Pselx, Prdata,
//                         Pready, Pslverr
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_fsm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic                  Pwrite;
    logic                  Penable;
    logic [NUM_SLAVES-1:0] Pselx;
    logic [DATA_WIDTH-1:0] Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  Prdata, Pready, Pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output Paddr, Pwdata, Pwrite, Penable, Pselx
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output Prdata, Pready, Pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Paddr, Pwdata, Pwrite, Penable, Pselx
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_fsm
// Description : APB requester with a SETUP/ACCESS state machine. Accepts one
//               transfer at a time on a valid/ready request port, decodes the
//               address into a one-hot Pselx, handles Pready wait states,
//               Pslverr, a wait-state timeout and decode errors, and returns
//               read data/status on a single-cycle rsp_valid pulse.
//               Ports:
//                 Hclk   - clock, rising edge
//                 Hreset - synchronous reset, active-high
//                 bus    - request/response + APB signals (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_fsm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  wire logic            Hclk,
    input  wire logic            Hreset,
    apb_master_fsm_if.master     bus
);

    localparam int c_sel_bits = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_cnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the Pready-low cycle that would bring the count to TIMEOUT.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DERR   = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_wait_cnt;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic                  r_penable;
    logic [NUM_SLAVES-1:0] r_pselx;

    logic [c_sel_bits-1:0] w_idx;
    logic                  w_idx_ok;
    logic [NUM_SLAVES-1:0] w_sel;

    // Decode is taken straight from the request so Pselx is valid in SETUP.
    assign w_idx    = bus.req_addr[SEL_LSB +: c_sel_bits];
    assign w_idx_ok = (32'(w_idx) < 32'(NUM_SLAVES));

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign w_sel[gi] = (32'(w_idx) == gi);
        end
    endgenerate

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_pselx     <= '0;
        end else begin
            // Response is a single-cycle pulse unless a branch below re-arms it.
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_paddr     <= bus.req_addr;
                        r_pwdata    <= bus.req_wdata;
                        r_pwrite    <= bus.req_write;
                        if (w_idx_ok) begin
                            r_pselx <= w_sel;
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_DERR;
                        end
                    end
                end

                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // Pready is checked first so it wins over a coincident timeout.
                    if (bus.Pready) begin
                        // Error responses never carry data.
                        r_rsp_rdata <= (r_pwrite || bus.Pslverr) ? '0 : bus.Prdata;
                        r_rsp_err   <= bus.Pslverr;
                        r_rsp_valid <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_pselx     <= '0;
                        r_penable   <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_state     <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_wait_cnt == c_cnt_last)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_pselx     <= '0;
                        r_penable   <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_state     <= ST_IDLE;
                    end else if (TIMEOUT != 0) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                ST_DERR: begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.Paddr     = r_paddr;
    assign bus.Pwdata    = r_pwdata;
    assign bus.Pwrite    = r_pwrite;
    assign bus.Penable   = r_penable;
    assign bus.Pselx     = r_pselx;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_fsm
// Description : Self-checking bench for apb_master_fsm. Directed cases plus
//               randomized transfers, compared cycle by cycle against a
//               transaction-level model of the expected bus timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_fsm;

    localparam int c_aw      = 32;
    localparam int c_dw      = 32;
    localparam int c_ns      = 3;
    localparam int c_sel_lsb = 12;
    localparam int c_timeout = 16;

    logic Hclk;
    logic Hreset;

    int n_total;
    int n_bad;

    logic [31:0] last_rd;
    logic        last_err;

    apb_master_fsm_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw), .NUM_SLAVES(c_ns)) bus ();

    apb_master_fsm #(
        .ADDR_WIDTH (c_aw),
        .DATA_WIDTH (c_dw),
        .NUM_SLAVES (c_ns),
        .SEL_LSB    (c_sel_lsb),
        .TIMEOUT    (c_timeout)
    ) u_dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level expectation: cycle k counts edges after acceptance.
    // Decode error -> response at k=2. Otherwise SETUP at k=1, ACCESS lasts
    // min(waits+1, TIMEOUT) cycles, response on the cycle after.
    task automatic do_xfer(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit slverr, input logic [31:0] prd,
                           input bit noise);
        int          idx;
        bit          derr;
        bit          tmo;
        int          acc_len;
        int          k_rsp;
        int          j;
        logic [2:0]  exp_sel;
        logic [31:0] exp_rd;
        bit          exp_err;

        idx     = int'((addr >> c_sel_lsb) & 32'h3);
        derr    = (idx >= c_ns);
        tmo     = !derr && (c_timeout != 0) && (waits >= c_timeout);
        acc_len = derr ? 0 : (tmo ? c_timeout : waits + 1);
        k_rsp   = acc_len + 2;
        exp_sel = derr ? 3'b000 : 3'(1 << idx);
        exp_err = derr || tmo || slverr;
        exp_rd  = (derr || tmo || slverr || w) ? 32'h0 : prd;

        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;

        for (int k = 1; k <= k_rsp; k++) begin
            @(posedge Hclk);
            #1;
            j = k - 1;
            bus.Pready  = !derr && (j >= 1) && (j <= acc_len) && (j == waits + 1);
            bus.Pslverr = bus.Pready ? slverr : 1'($urandom);
            bus.Prdata  = bus.Pready ? prd : $urandom;
            if (noise && (k != k_rsp)) begin
                bus.req_valid = 1'($urandom);
                bus.req_write = 1'($urandom);
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge Hclk);
            check("pselx",     64'(bus.Pselx),     64'((!derr && k <= acc_len + 1) ? exp_sel : 3'b000));
            check("penable",   64'(bus.Penable),   64'(!derr && k >= 2 && k <= acc_len + 1));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(k == k_rsp));
            check("req_ready", 64'(bus.req_ready), 64'(k == k_rsp));
            check("paddr",     64'(bus.Paddr),     64'(addr));
            check("pwdata",    64'(bus.Pwdata),    64'(wdata));
            check("pwrite",    64'(bus.Pwrite),    64'(w));
            if (k == k_rsp) begin
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
                check("rsp_err",   64'(bus.rsp_err),   64'(exp_err));
                last_rd  = exp_rd;
                last_err = exp_err;
            end else begin
                check("rdata_hold", 64'(bus.rsp_rdata), 64'(last_rd));
                check("err_hold",   64'(bus.rsp_err),   64'(last_err));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Hclk);
            #1;
            bus.req_valid = 1'b0;
            bus.Pready    = 1'($urandom);
            bus.Pslverr   = 1'($urandom);
            bus.Prdata    = $urandom;
            @(negedge Hclk);
            check("idle_ready",   64'(bus.req_ready), 64'(1));
            check("idle_rsp",     64'(bus.rsp_valid), 64'(0));
            check("idle_penable", 64'(bus.Penable),   64'(0));
            check("idle_pselx",   64'(bus.Pselx),     64'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
        check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'(0));
        check({tag, "_paddr"},     64'(bus.Paddr),     64'(0));
        check({tag, "_pwdata"},    64'(bus.Pwdata),    64'(0));
        check({tag, "_pwrite"},    64'(bus.Pwrite),    64'(0));
        check({tag, "_penable"},   64'(bus.Penable),   64'(0));
        check({tag, "_pselx"},     64'(bus.Pselx),     64'(0));
    endtask

    // Leaves the bench at a negedge in a cycle where req_ready is high.
    task automatic apply_reset(input int n);
        @(posedge Hclk);
        #1;
        Hreset = 1'b1;
        bus.req_valid = 1'b0;
        bus.Pready    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge Hclk);
        end
        @(negedge Hclk);
        check_all_zero("rst");
        @(posedge Hclk);
        #1;
        Hreset = 1'b0;
        @(negedge Hclk);
        check("rst_rel_ready0", 64'(bus.req_ready), 64'(0));
        @(posedge Hclk);
        @(negedge Hclk);
        check("rst_rel_ready1", 64'(bus.req_ready), 64'(1));
        check("rst_rel_rsp",    64'(bus.rsp_valid), 64'(0));
        last_rd  = 32'h0;
        last_err = 1'b0;
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        last_rd       = 32'h0;
        last_err      = 1'b0;
        Hreset        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.Prdata    = '0;
        bus.Pready    = 1'b0;
        bus.Pslverr   = 1'b0;

        apply_reset(3);

        // Directed cases
        do_xfer(1'b0, 32'h0000_1010, 32'h1111_2222, 0,   1'b0, 32'hCAFE_F00D, 1'b0);
        idle(2);
        do_xfer(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 3,   1'b0, 32'h5555_AAAA, 1'b0);
        idle(1);
        do_xfer(1'b0, 32'h0000_2000, 32'h0,         0,   1'b1, 32'h1234_5678, 1'b0);
        idle(1);
        do_xfer(1'b0, 32'h0000_3000, 32'h7777_0000, 0,   1'b0, 32'h9999_9999, 1'b0);
        idle(1);
        do_xfer(1'b0, 32'h0000_1004, 32'h0,         100, 1'b0, 32'hABCD_EF01, 1'b0);
        idle(1);
        do_xfer(1'b0, 32'h0000_0008, 32'h0,         c_timeout - 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
        // Back-to-back: next request is presented in the response cycle
        do_xfer(1'b1, 32'h0000_2100, 32'h0102_0304, 0,   1'b0, 32'h0,         1'b0);
        do_xfer(1'b0, 32'h0000_1200, 32'h0,         1,   1'b0, 32'hFEED_FACE, 1'b0);

        // Reset during ACCESS: no response for the in-flight write
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0ABC;
        bus.req_wdata = 32'h00C0_FFEE;
        @(posedge Hclk);
        #1;
        bus.req_valid = 1'b0;
        bus.Pready    = 1'b0;
        @(posedge Hclk);
        @(negedge Hclk);
        check("pre_rst_penable", 64'(bus.Penable), 64'(1));
        @(posedge Hclk);
        #1;
        Hreset = 1'b1;
        @(posedge Hclk);
        @(negedge Hclk);
        check_all_zero("mid_rst");
        @(posedge Hclk);
        #1;
        Hreset = 1'b0;
        @(negedge Hclk);
        check("post_rst_ready0", 64'(bus.req_ready), 64'(0));
        check("post_rst_rsp0",   64'(bus.rsp_valid), 64'(0));
        @(posedge Hclk);
        @(negedge Hclk);
        check("post_rst_ready1", 64'(bus.req_ready), 64'(1));
        check("post_rst_rsp1",   64'(bus.rsp_valid), 64'(0));
        last_rd  = 32'h0;
        last_err = 1'b0;

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int          wt;
            a  = $urandom;
            wt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20))
                                             : int'($urandom_range(0, 15));
            do_xfer(1'($urandom), a, $urandom, wt, 1'($urandom_range(0, 3) == 0),
                    $urandom, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
Parametrised APB requester: the next generation of the bridge's APB-side interface. It replaces the pass-through APB interface with a real SETUP/ACCESS state machine. It accepts one transfer at a time on a valid/ready request port and decodes the address to a one-hot Pselx over NUM_SLAVES slaves. It supports Pready wait states, Pslverr, a wait-state timeout and decode errors, and returns Prdata/status on a single-cycle response pulse.

Parameters:
ADDR_WIDTH, 32, width of req_addr/Paddr
DATA_WIDTH, 32, width of write/read data buses
NUM_SLAVES, 3, number of Pselx lines (>=1)
SEL_LSB, 12, LSB of slave-index field in address; index = addr[SEL_LSB +: SEL_BITS], SEL_BITS = max(1, clog2(NUM_SLAVES))
TIMEOUT, 16, consecutive Pready-low ACCESS cycles before abort; 0 disables timeout

Ports:
Hclk  in  1  clock, all logic on rising edge
Hreset  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  transfer address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  Pslverr, decode error or timeout
Paddr  out  ADDR_WIDTH  APB address
Pwdata  out  DATA_WIDTH  APB write data
Pwrite  out  1  APB direction
Penable  out  1  APB enable (ACCESS phase)
Pselx  out  NUM_SLAVES  one-hot APB select
Prdata  in  DATA_WIDTH  muxed slave read data
Pready  in  1  slave ready
Pslverr  in  1  slave error, sampled with Pready

Behaviour:
- All outputs registered. Reset values: req_ready=0 during reset then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, Paddr=0, Pwdata=0, Pwrite=0, Penable=0, Pselx=0. State=IDLE, wait counter=0.
- States: IDLE, SETUP, ACCESS, DERR.
- IDLE: req_ready=1. On req_valid&req_ready at an edge, register addr/wdata/write into Paddr/Pwdata/Pwrite.
  - If index < NUM_SLAVES, go to SETUP.
  - Otherwise go to DERR.
- SETUP (1 cycle): Pselx[index]=1, Penable=0, req_ready=0. Then go to ACCESS.
- ACCESS: Pselx held, Penable=1, Paddr/Pwdata/Pwrite stable.
  - Pready=1: capture rsp_rdata = Prdata for reads (0 for writes) and rsp_err = Pslverr. Next cycle rsp_valid=1, Pselx=0, Penable=0, state IDLE.
  - Pready=0: increment wait counter.
  - TIMEOUT!=0 and counter reaches TIMEOUT: abort. Next cycle Pselx=0, Penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE.
  - Counter clears on leaving ACCESS.
- DERR (1 cycle): no Pselx asserted. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE.
- Latency with zero wait states: accept at edge N, SETUP at N+1, ACCESS at N+2, rsp_valid and req_ready=1 at N+3. A new request is accepted at N+3, giving SETUP at N+4 with no idle gap.
- rsp_valid is high for exactly 1 cycle and is not backpressured. rsp_rdata/rsp_err hold until the next response.
- Paddr/Pwdata/Pwrite keep their last values after a transfer; they are not cleared.
- Pslverr is ignored while Pready=0.
- Simultaneous Pready=1 and timeout reached in the same cycle: Pready wins, normal completion.
- Hreset during any state: next edge returns all outputs to reset values and IDLE. No response is issued for the in-flight transfer.
- req_* inputs are ignored while req_ready=0.

Test Plan:
- Zero-wait read: req addr 0x0000_1010, write=0, Pready=1, Prdata=0xCAFE_F00D -> Pselx=3'b010 at N+1, Penable at N+2, rsp_valid at N+3 with rdata 0xCAFE_F00D, err 0.
- Write with 3 wait states: addr 0x0000_0020, wdata 0xDEAD_BEEF, Pready low 3 cycles -> Penable held 4 cycles, Pwdata stable 0xDEAD_BEEF, rsp_valid 1 cycle after Pready, rdata 0, err 0.
- Slave error: read of addr 0x0000_2000 with Pready=1, Pslverr=1 -> Pselx=3'b100, rsp_err=1.
- Decode error: addr 0x0000_3000 (index 3 >= NUM_SLAVES) -> Pselx stays 0, rsp_valid at N+2 with err=1, rdata=0.
- Timeout: TIMEOUT=16, Pready held low -> abort after 16 ACCESS cycles, Pselx/Penable drop, rsp_err=1. Separately, Pready rising exactly on the 16th cycle -> normal completion.
- Back-to-back and reset: two requests with req_valid held high -> second SETUP directly follows first rsp cycle. Hreset asserted during ACCESS -> all outputs 0 next edge, no rsp_valid, req_ready=1 after release.
